multiplier_controller_tainttrack: RTL and testbench

- Control FSM for the taint-tracked shift-add sequential multiplier; sits directly upstream of MultiplierDatapath_TaintTrack.
- Drives rsclear/mrld/mdld/rsload/rsshr and consumes multiplierReg/multiplierReg_t back from the datapath.
- Emits a shadow taint bit on every control output and on done, so implicit (control-flow) taint reaches the datapath.

---
 rtl/multiplier_controller_tainttrack.sv | 189 ++++++++++++++++++
 tb/tb_multiplier_controller_tainttrack.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_controller_tainttrack.sv
//============================================================================
// Module   : multiplier_controller_tainttrack
// Purpose  : Control FSM for the taint-tracked shift-add sequential
//            multiplier. Sequences the datapath through clear/load, then
//            WIDTH add/shift iterations, then a one-cycle done pulse. Every
//            control output has a shadow taint bit, so control-flow
//            (implicit) taint reaches the datapath alongside the strobes.
// Revision : 1.0 - initial release
//----------------------------------------------------------------------------
// Parameters
//   WIDTH            operand width; must match the datapath WIDTH
// Ports
//   clk              clock, all state changes on posedge
//   rst_n            synchronous active-low reset
//   start / start_t  begin a multiply (sampled in IDLE only) and its taint
//   multiplierReg    multiplier register fed back from the datapath
//   multiplierReg_t  taint of multiplierReg
//   rsclear(_t)      clear running sum
//   mrld(_t)         load multiplier register
//   mdld(_t)         load multiplicand register
//   rsload(_t)       add multiplicand into running sum (data dependent)
//   rsshr(_t)        arithmetic shift-right of running sum
//   busy             high in every state except IDLE
//   done(_t)         one-cycle completion pulse and its taint
// Build options
//   CTRL_IMPLICIT_TAINT_EN  when defined, a tainted multiplier bit seen in
//                           an ADD cycle makes the whole remainder of the
//                           operation's control outputs tainted.
//============================================================================
`default_nettype none

module multiplier_controller_tainttrack #(
    parameter int WIDTH = 2048
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             start_t,
    input  logic [WIDTH-1:0] multiplierReg,
    input  logic [WIDTH-1:0] multiplierReg_t,
    output logic             rsclear,
    output logic             rsclear_t,
    output logic             mrld,
    output logic             mrld_t,
    output logic             mdld,
    output logic             mdld_t,
    output logic             rsload,
    output logic             rsload_t,
    output logic             rsshr,
    output logic             rsshr_t,
    output logic             busy,
    output logic             done,
    output logic             done_t
);

    // Iteration counter is one bit wider than an index so the terminal
    // value never aliases; only the low IDX_W bits select the multiplier bit.
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_ctrl_taint;
    logic             w_ctrl_taint_nxt;

    logic [IDX_W-1:0] w_idx;
    logic             w_mr_bit;
    logic             w_mr_bit_t;

    // The counter stays within 0..WIDTH-1 whenever it is used as an index,
    // so the truncated index is exact.
    assign w_idx      = r_cnt[IDX_W-1:0];
    assign w_mr_bit   = multiplierReg[w_idx];
    assign w_mr_bit_t = multiplierReg_t[w_idx];

    //------------------------------------------------------------------------
    // State register
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_ctrl_taint <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ctrl_taint <= w_ctrl_taint_nxt;
        end
    end

    //------------------------------------------------------------------------
    // Next-state and output decode. All outputs are Moore decodes of the
    // state except rsload/rsload_t, which also look at the multiplier bit
    // currently selected by the counter.
    //------------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_ctrl_taint_nxt = r_ctrl_taint;

        rsclear   = 1'b0;
        rsclear_t = 1'b0;
        mrld      = 1'b0;
        mrld_t    = 1'b0;
        mdld      = 1'b0;
        mdld_t    = 1'b0;
        rsload    = 1'b0;
        rsload_t  = 1'b0;
        rsshr     = 1'b0;
        rsshr_t   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        done_t    = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                // No taint is reported here even if start_t is high: an
                // unasserted start does not steer anything.
                busy = 1'b0;
                if (start) begin
                    w_state_nxt      = S_INIT;
                    w_cnt_nxt        = '0;
                    w_ctrl_taint_nxt = start_t;
                end
            end

            S_INIT: begin
                rsclear     = 1'b1;
                mrld        = 1'b1;
                mdld        = 1'b1;
                rsclear_t   = r_ctrl_taint;
                mrld_t      = r_ctrl_taint;
                mdld_t      = r_ctrl_taint;
                w_state_nxt = S_ADD;
            end

            S_ADD: begin
                // A tainted multiplier bit taints the add decision whether
                // or not the add actually happens.
                rsload   = w_mr_bit;
                rsload_t = r_ctrl_taint | w_mr_bit_t;
`ifdef CTRL_IMPLICIT_TAINT_EN
                // Conservative implicit flow: once a tainted bit has steered
                // the sequence, everything after it is considered tainted.
                if (w_mr_bit_t) begin
                    w_ctrl_taint_nxt = 1'b1;
                end
`endif
                w_state_nxt = S_SHIFT;
            end

            S_SHIFT: begin
                rsshr   = 1'b1;
                rsshr_t = r_ctrl_taint;
                if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                    w_state_nxt = S_ADD;
                end
            end

            S_DONE: begin
                done        = 1'b1;
                done_t      = r_ctrl_taint;
                w_state_nxt = S_IDLE;
            end

            default: begin
                busy        = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_multiplier_controller_tainttrack.sv
//============================================================================
// Module   : tb_multiplier_controller_tainttrack
// Purpose  : Self-checking bench for multiplier_controller_tainttrack at
//            WIDTH=4. Table of per-cycle {inputs, expected outputs} records
//            plus a hand-written busy/done latency sequence.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_multiplier_controller_tainttrack;

    localparam int W = 4;

`ifdef CTRL_IMPLICIT_TAINT_EN
    localparam logic IMP = 1'b1;
`else
    localparam logic IMP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         start_t;
    logic [W-1:0] mr;
    logic [W-1:0] mr_t;
    logic         rsclear, rsclear_t, mrld, mrld_t, mdld, mdld_t;
    logic         rsload, rsload_t, rsshr, rsshr_t, busy, done, done_t;

    multiplier_controller_tainttrack #(.WIDTH(W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .start_t         (start_t),
        .multiplierReg   (mr),
        .multiplierReg_t (mr_t),
        .rsclear         (rsclear),
        .rsclear_t       (rsclear_t),
        .mrld            (mrld),
        .mrld_t          (mrld_t),
        .mdld            (mdld),
        .mdld_t          (mdld_t),
        .rsload          (rsload),
        .rsload_t        (rsload_t),
        .rsshr           (rsshr),
        .rsshr_t         (rsshr_t),
        .busy            (busy),
        .done            (done),
        .done_t          (done_t)
    );

    always #5 clk = ~clk;

    // Expected word bit order:
    // {busy, rsclear, mrld, mdld, rsload, rsshr, done,
    //  rsclear_t, mrld_t, mdld_t, rsload_t, rsshr_t, done_t}
    typedef struct {
        int           scen;
        int           cyc;
        logic         rst_n;
        logic         start;
        logic         start_t;
        logic [W-1:0] mr;
        logic [W-1:0] mr_t;
        logic [12:0]  exp;
    } vec_t;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [12:0] e_idle();
        return 13'b0;
    endfunction

    function automatic logic [12:0] e_init(input logic t);
        return {1'b1, 3'b111, 3'b000, t, t, t, 3'b000};
    endfunction

    function automatic logic [12:0] e_add(input logic ld, input logic t);
        return {1'b1, 3'b000, ld, 2'b00, 3'b000, t, 2'b00};
    endfunction

    function automatic logic [12:0] e_shift(input logic t);
        return {1'b1, 3'b000, 3'b010, 3'b000, 1'b0, t, 1'b0};
    endfunction

    function automatic logic [12:0] e_done(input logic t);
        return {1'b1, 3'b000, 3'b001, 3'b000, 2'b00, t};
    endfunction

    task automatic v(input int scen, input int cyc, input logic rn,
                     input logic s, input logic st,
                     input logic [W-1:0] m, input logic [W-1:0] mt,
                     input logic [12:0] e);
        vec_t r;
        r.scen = scen; r.cyc = cyc; r.rst_n = rn; r.start = s;
        r.start_t = st; r.mr = m; r.mr_t = mt; r.exp = e;
        vq.push_back(r);
    endtask

    task automatic check(input string nm, input int got, input int req);
        n_checks++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, got, req);
        end
    endtask

    initial begin
        logic [12:0] got;
        int busy_cnt, done_cnt, done_pos, seen_end;

        //--------------------------------------------------------------------
        // 1: idle after reset; start_t / multiplier taint without start
        //--------------------------------------------------------------------
        v(1, 0, 1, 0, 0, 4'b0000, 4'b0000, e_idle());
        v(1, 1, 1, 0, 1, 4'b0000, 4'b0000, e_idle());
        v(1, 2, 1, 0, 1, 4'b1111, 4'b1111, e_idle());
        v(1, 3, 1, 0, 0, 4'b1010, 4'b0101, e_idle());
        v(1, 4, 1, 0, 0, 4'b0000, 4'b0000, e_idle());

        // 2: untainted multiply, mr=1010 -> rsload 0,1,0,1
        v(2, 0,  1, 1, 0, 4'b1010, 4'b0000, e_idle());
        v(2, 1,  1, 0, 0, 4'b1010, 4'b0000, e_init(0));
        v(2, 2,  1, 0, 0, 4'b1010, 4'b0000, e_add(0, 0));
        v(2, 3,  1, 0, 0, 4'b1010, 4'b0000, e_shift(0));
        v(2, 4,  1, 0, 0, 4'b1010, 4'b0000, e_add(1, 0));
        v(2, 5,  1, 0, 0, 4'b1010, 4'b0000, e_shift(0));
        v(2, 6,  1, 0, 0, 4'b1010, 4'b0000, e_add(0, 0));
        v(2, 7,  1, 0, 0, 4'b1010, 4'b0000, e_shift(0));
        v(2, 8,  1, 0, 0, 4'b1010, 4'b0000, e_add(1, 0));
        v(2, 9,  1, 0, 0, 4'b1010, 4'b0000, e_shift(0));
        v(2, 10, 1, 0, 0, 4'b1010, 4'b0000, e_done(0));
        v(2, 11, 1, 0, 0, 4'b1010, 4'b0000, e_idle());

        // 3: tainted start, mr=1111 -> every asserted control tainted
        v(3, 0,  1, 1, 1, 4'b1111, 4'b0000, e_idle());
        v(3, 1,  1, 0, 0, 4'b1111, 4'b0000, e_init(1));
        v(3, 2,  1, 0, 0, 4'b1111, 4'b0000, e_add(1, 1));
        v(3, 3,  1, 0, 0, 4'b1111, 4'b0000, e_shift(1));
        v(3, 4,  1, 0, 0, 4'b1111, 4'b0000, e_add(1, 1));
        v(3, 5,  1, 0, 0, 4'b1111, 4'b0000, e_shift(1));
        v(3, 6,  1, 0, 0, 4'b1111, 4'b0000, e_add(1, 1));
        v(3, 7,  1, 0, 0, 4'b1111, 4'b0000, e_shift(1));
        v(3, 8,  1, 0, 0, 4'b1111, 4'b0000, e_add(1, 1));
        v(3, 9,  1, 0, 0, 4'b1111, 4'b0000, e_shift(1));
        v(3, 10, 1, 0, 0, 4'b1111, 4'b0000, e_done(1));
        v(3, 11, 1, 0, 1, 4'b1111, 4'b0000, e_idle());

        // 4: multiplier bit 2 tainted (ADD in cycle 6)
        v(4, 0,  1, 1, 0, 4'b0000, 4'b0100, e_idle());
        v(4, 1,  1, 0, 0, 4'b0000, 4'b0100, e_init(0));
        v(4, 2,  1, 0, 0, 4'b0000, 4'b0100, e_add(0, 0));
        v(4, 3,  1, 0, 0, 4'b0000, 4'b0100, e_shift(0));
        v(4, 4,  1, 0, 0, 4'b0000, 4'b0100, e_add(0, 0));
        v(4, 5,  1, 0, 0, 4'b0000, 4'b0100, e_shift(0));
        v(4, 6,  1, 0, 0, 4'b0000, 4'b0100, e_add(0, 1));
        v(4, 7,  1, 0, 0, 4'b0000, 4'b0100, e_shift(IMP));
        v(4, 8,  1, 0, 0, 4'b0000, 4'b0100, e_add(0, IMP));
        v(4, 9,  1, 0, 0, 4'b0000, 4'b0100, e_shift(IMP));
        v(4, 10, 1, 0, 0, 4'b0000, 4'b0100, e_done(IMP));
        v(4, 11, 1, 0, 0, 4'b0000, 4'b0100, e_idle());

        // 5: tainted start while busy is ignored; back-to-back restart
        v(5, 0,  1, 1, 0, 4'b0110, 4'b0000, e_idle());
        v(5, 1,  1, 0, 0, 4'b0110, 4'b0000, e_init(0));
        v(5, 2,  1, 0, 0, 4'b0110, 4'b0000, e_add(0, 0));
        v(5, 3,  1, 0, 0, 4'b0110, 4'b0000, e_shift(0));
        v(5, 4,  1, 0, 0, 4'b0110, 4'b0000, e_add(1, 0));
        v(5, 5,  1, 1, 1, 4'b0110, 4'b0000, e_shift(0));
        v(5, 6,  1, 0, 0, 4'b0110, 4'b0000, e_add(1, 0));
        v(5, 7,  1, 0, 0, 4'b0110, 4'b0000, e_shift(0));
        v(5, 8,  1, 0, 0, 4'b0110, 4'b0000, e_add(0, 0));
        v(5, 9,  1, 0, 0, 4'b0110, 4'b0000, e_shift(0));
        v(5, 10, 1, 0, 0, 4'b0110, 4'b0000, e_done(0));
        v(5, 11, 1, 1, 0, 4'b0110, 4'b0000, e_idle());
        v(5, 12, 1, 0, 0, 4'b0110, 4'b0000, e_init(0));
        v(5, 13, 1, 0, 0, 4'b0110, 4'b0000, e_add(0, 0));
        v(5, 14, 1, 0, 0, 4'b0110, 4'b0000, e_shift(0));
        v(5, 15, 1, 0, 0, 4'b0110, 4'b0000, e_add(1, 0));
        v(5, 16, 1, 0, 0, 4'b0110, 4'b0000, e_shift(0));
        v(5, 17, 1, 0, 0, 4'b0110, 4'b0000, e_add(1, 0));
        v(5, 18, 1, 0, 0, 4'b0110, 4'b0000, e_shift(0));
        v(5, 19, 1, 0, 0, 4'b0110, 4'b0000, e_add(0, 0));
        v(5, 20, 1, 0, 0, 4'b0110, 4'b0000, e_shift(0));
        v(5, 21, 1, 0, 0, 4'b0110, 4'b0000, e_done(0));
        v(5, 22, 1, 0, 0, 4'b0110, 4'b0000, e_idle());

        // 6: reset in cycle 6 aborts and clears taint; reset beats start
        v(6, 0,  1, 1, 1, 4'b1111, 4'b0000, e_idle());
        v(6, 1,  1, 0, 0, 4'b1111, 4'b0000, e_init(1));
        v(6, 2,  1, 0, 0, 4'b1111, 4'b0000, e_add(1, 1));
        v(6, 3,  1, 0, 0, 4'b1111, 4'b0000, e_shift(1));
        v(6, 4,  1, 0, 0, 4'b1111, 4'b0000, e_add(1, 1));
        v(6, 5,  1, 0, 0, 4'b1111, 4'b0000, e_shift(1));
        v(6, 6,  0, 0, 0, 4'b1111, 4'b0000, e_add(1, 1));
        v(6, 7,  0, 1, 1, 4'b1111, 4'b0000, e_idle());
        v(6, 8,  1, 1, 0, 4'b1111, 4'b0000, e_idle());
        v(6, 9,  1, 0, 0, 4'b1111, 4'b0000, e_init(0));
        v(6, 10, 1, 0, 0, 4'b1111, 4'b0000, e_add(1, 0));
        v(6, 11, 1, 0, 0, 4'b1111, 4'b0000, e_shift(0));
        v(6, 12, 1, 0, 0, 4'b1111, 4'b0000, e_add(1, 0));
        v(6, 13, 1, 0, 0, 4'b1111, 4'b0000, e_shift(0));
        v(6, 14, 1, 0, 0, 4'b1111, 4'b0000, e_add(1, 0));
        v(6, 15, 1, 0, 0, 4'b1111, 4'b0000, e_shift(0));
        v(6, 16, 1, 0, 0, 4'b1111, 4'b0000, e_add(1, 0));
        v(6, 17, 1, 0, 0, 4'b1111, 4'b0000, e_shift(0));
        v(6, 18, 1, 0, 0, 4'b1111, 4'b0000, e_done(0));
        v(6, 19, 1, 0, 0, 4'b1111, 4'b0000, e_idle());

        //--------------------------------------------------------------------
        // Reset: two cycles with rst_n low, then apply the table. Inputs
        // change at negedge, outputs are compared 1ns later.
        //--------------------------------------------------------------------
        rst_n = 1'b0; start = 1'b0; start_t = 1'b0; mr = '0; mr_t = '0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            rst_n   = vq[i].rst_n;
            start   = vq[i].start;
            start_t = vq[i].start_t;
            mr      = vq[i].mr;
            mr_t    = vq[i].mr_t;
            #1;
            got = {busy, rsclear, mrld, mdld, rsload, rsshr, done,
                   rsclear_t, mrld_t, mdld_t, rsload_t, rsshr_t, done_t};
            n_checks++;
            if (got !== vq[i].exp) begin
                n_fail++;
                $display("FAIL scen%0d cycle%0d outputs: got %b required %b",
                         vq[i].scen, vq[i].cyc, got, vq[i].exp);
            end
        end

        //--------------------------------------------------------------------
        // Hand-written sequence: busy lasts 2*W+2 cycles with a single done
        // in the last busy cycle; bounded so a stuck FSM still terminates.
        //--------------------------------------------------------------------
        @(negedge clk);
        rst_n = 1'b1; start = 1'b1; start_t = 1'b0; mr = 4'b1001; mr_t = '0;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0; done_cnt = 0; done_pos = -1; seen_end = 0;
        for (int k = 0; k < 40 && seen_end == 0; k++) begin
            #1;
            if (busy) begin
                if (done) begin
                    done_cnt++;
                    done_pos = busy_cnt;
                end
                busy_cnt++;
            end else begin
                seen_end = 1;
            end
            @(negedge clk);
        end
        check("busy_returns_low", seen_end, 1);
        check("busy_cycles", busy_cnt, 2 * W + 2);
        check("done_pulses", done_cnt, 1);
        check("done_position", done_pos, 2 * W + 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
